// File: rtl/scrisc_pkg.sv
// Shared SCRISC-16 definitions: operation and multiply/divide state encodings,
// plus the architectural register index width.
package scrisc_pkg;

  localparam int REG_IDX_W = 2;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide for the SCRISC-16 execute stage: one
// shift-add or restoring-divide step per clock, result written back with done.
module mul_div_unit
  import scrisc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int RW    = REG_IDX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [RW-1:0]      dst,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic [RW-1:0]      wr_reg,
  output logic               div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  md_state_e          state_reg, state_next;
  md_op_e             op_reg, op_next;
  logic [CW-1:0]      count_reg, count_next, count_inc;
  logic [2*WIDTH:0]   acc_reg, acc_next;
  logic [WIDTH-1:0]   opb_reg, opb_next;
  logic [RW-1:0]      dst_reg, dst_next;
  logic [2*WIDTH-1:0] result_reg, result_next;
  logic [RW-1:0]      wr_idx_reg, wr_idx_next;
  logic               div_zero_reg, div_zero_next;

  logic               accept, zero_div, div_ge;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH:0]   mul_step, div_step, step;

  assign accept   = start && !flush && (state_reg == MD_IDLE || state_reg == MD_DONE);
  assign zero_div = (op_reg == OP_DIV) && (opb_reg == '0);

  // acc holds {upper partial, operand A}; both algorithms shift A out of the
  // low half, so the final {hi,lo} / {rem,quo} lands in acc[2W-1:0].
  assign mul_sum  = acc_reg[2*WIDTH:WIDTH] + {1'b0, opb_reg};
  assign mul_step = acc_reg[0] ? {1'b0, mul_sum, acc_reg[WIDTH-1:1]}
                               : {1'b0, acc_reg[2*WIDTH:1]};

  assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opb_reg};
  assign div_diff  = div_shift - {1'b0, opb_reg};
  assign div_step  = div_ge ? {div_diff, acc_reg[WIDTH-2:0], 1'b1}
                            : {div_shift, acc_reg[WIDTH-2:0], 1'b0};

  assign step      = (op_reg == OP_DIV) ? div_step : mul_step;
  assign count_inc = (count_reg == CNT_LAST) ? count_reg : count_reg + CW'(1);

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    count_next    = count_reg;
    acc_next      = acc_reg;
    opb_next      = opb_reg;
    dst_next      = dst_reg;
    result_next   = result_reg;
    wr_idx_next   = wr_idx_reg;
    div_zero_next = div_zero_reg;

    case (state_reg)
      MD_IDLE: begin
        if (accept) state_next = MD_CALC;
      end
      MD_CALC: begin
        if (flush) begin
          state_next = MD_IDLE;
        end else if (zero_div) begin
          // Dividend is still untouched in the low half of acc.
          state_next    = MD_DONE;
          result_next   = {acc_reg[WIDTH-1:0], {WIDTH{1'b1}}};
          wr_idx_next   = dst_reg;
          div_zero_next = 1'b1;
        end else begin
          acc_next   = step;
          count_next = count_inc;
          if (count_inc == CNT_LAST) begin
            state_next  = MD_DONE;
            result_next = step[2*WIDTH-1:0];
            wr_idx_next = dst_reg;
          end
        end
      end
      MD_DONE: begin
        state_next = accept ? MD_CALC : MD_IDLE;
      end
      default: state_next = MD_IDLE;
    endcase

    if (accept) begin
      op_next       = md_op_e'(op);
      opb_next      = b;
      dst_next      = dst;
      acc_next      = {{(WIDTH + 1){1'b0}}, a};
      count_next    = '0;
      div_zero_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= MD_IDLE;
      op_reg       <= OP_MUL;
      count_reg    <= '0;
      acc_reg      <= '0;
      opb_reg      <= '0;
      dst_reg      <= '0;
      result_reg   <= '0;
      wr_idx_reg   <= '0;
      div_zero_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      count_reg    <= count_next;
      acc_reg      <= acc_next;
      opb_reg      <= opb_next;
      dst_reg      <= dst_next;
      result_reg   <= result_next;
      wr_idx_reg   <= wr_idx_next;
      div_zero_reg <= div_zero_next;
    end
  end

  assign busy     = (state_reg == MD_CALC);
  assign done     = (state_reg == MD_DONE);
  assign result   = result_reg;
  assign wr_reg   = wr_idx_reg;
  assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed and randomized MUL/DIV ops
// compared against plain-arithmetic expectations, plus control scenarios.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, op, flush;
  logic [15:0] a, b;
  logic [1:0]  dst;
  logic        busy, done, div_zero;
  logic [31:0] result;
  logic [1:0]  wr_reg;

  int n_cmp = 0;
  int n_err = 0;

  mul_div_unit #(.WIDTH(16), .RW(2)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .dst(dst),
    .flush(flush), .busy(busy), .done(done), .result(result), .wr_reg(wr_reg),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Issue one op from idle and wait (bounded) for its done pulse.
  task automatic run_op(input logic o, input logic [15:0] x, input logic [15:0] y,
                        input logic [1:0] d, output int lat, output logic [31:0] res,
                        output logic [1:0] wr, output logic dz, output logic done_after);
    bit seen;
    seen = 1'b0; lat = -1; res = '0; wr = '0; dz = 1'b0; done_after = 1'b0;
    @(negedge clk); start = 1'b1; op = o; a = x; b = y; dst = d;
    @(negedge clk); start = 1'b0; op = ~o; a = ~x; b = ~y; dst = ~d;
    for (int k = 0; k <= 40 && !seen; k++) begin
      if (k > 0) @(negedge clk);
      if (done) begin
        seen = 1'b1; lat = k; res = result; wr = wr_reg; dz = div_zero;
      end
    end
    if (seen) begin @(negedge clk); done_after = done; end
    $display("op=%s a=%h b=%h dst=%0d -> result=%h wr_reg=%0d div_zero=%0b latency=%0d",
             o ? "DIV" : "MUL", x, y, d, res, wr, dz, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 1'b0; flush = 1'b0; a = '0; b = '0; dst = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy, done, div_zero} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_zero}); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h expected 00000000", result); end
    n_cmp++; if (wr_reg !== 2'd0) begin n_err++; $display("FAIL reset_wr_reg: got %0d expected 0", wr_reg); end
    reset = 1'b0;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_mul();
    int lat; logic [31:0] res; logic [1:0] wr; logic dz, da;
    logic [15:0] x, y; logic [1:0] d;
    run_op(1'b0, 16'd3, 16'd5, 2'd2, lat, res, wr, dz, da);
    n_cmp++; if (lat !== 16) begin n_err++; $display("FAIL mul_latency: got %0d expected 16", lat); end
    n_cmp++; if (res !== 32'h0000000F) begin n_err++; $display("FAIL mul_3x5: got %h expected 0000000f", res); end
    n_cmp++; if (wr !== 2'd2) begin n_err++; $display("FAIL mul_wr_reg: got %0d expected 2", wr); end
    n_cmp++; if (da !== 1'b0) begin n_err++; $display("FAIL mul_done_width: done still %b one cycle later, expected 0", da); end
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 2'd0, lat, res, wr, dz, da);
    n_cmp++; if (res !== 32'hFFFE0001) begin n_err++; $display("FAIL mul_max: got %h expected fffe0001", res); end
    n_cmp++; if (dz !== 1'b0) begin n_err++; $display("FAIL mul_div_zero: got %b expected 0", dz); end
    for (int i = 0; i < 8; i++) begin
      x = 16'($urandom); y = 16'($urandom); d = 2'($urandom);
      if (i == 0) y = 16'd0;
      run_op(1'b0, x, y, d, lat, res, wr, dz, da);
      n_cmp++; if (res !== 32'(x) * 32'(y)) begin n_err++; $display("FAIL mul_rand: %h*%h got %h expected %h", x, y, res, 32'(x) * 32'(y)); end
      n_cmp++; if (lat !== 16 || wr !== d) begin n_err++; $display("FAIL mul_rand_ctl: latency %0d wr_reg %0d expected 16 / %0d", lat, wr, d); end
    end
  endtask

  task automatic test_div();
    int lat; logic [31:0] res, exp; logic [1:0] wr; logic dz, da;
    logic [15:0] x, y; logic [1:0] d;
    run_op(1'b1, 16'd100, 16'd7, 2'd1, lat, res, wr, dz, da);
    n_cmp++; if (lat !== 16) begin n_err++; $display("FAIL div_latency: got %0d expected 16", lat); end
    n_cmp++; if (res !== 32'h0002000E) begin n_err++; $display("FAIL div_100_7: got %h expected 0002000e", res); end
    n_cmp++; if (wr !== 2'd1) begin n_err++; $display("FAIL div_wr_reg: got %0d expected 1", wr); end
    for (int i = 0; i < 8; i++) begin
      x = 16'($urandom);
      y = (i < 3) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
      if (i == 7) y = x | 16'd1;
      d = 2'($urandom);
      exp = {x % y, x / y};
      run_op(1'b1, x, y, d, lat, res, wr, dz, da);
      n_cmp++; if (res !== exp) begin n_err++; $display("FAIL div_rand: %h/%h got %h expected %h", x, y, res, exp); end
      n_cmp++; if (lat !== 16 || dz !== 1'b0 || wr !== d) begin n_err++; $display("FAIL div_rand_ctl: latency %0d div_zero %b wr_reg %0d expected 16/0/%0d", lat, dz, wr, d); end
    end
  endtask

  task automatic test_div_zero();
    int lat; logic [31:0] res; logic [1:0] wr; logic dz, da;
    run_op(1'b1, 16'h1234, 16'h0000, 2'd3, lat, res, wr, dz, da);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL dz_latency: got %0d expected 1", lat); end
    n_cmp++; if (res !== 32'h1234FFFF) begin n_err++; $display("FAIL dz_result: got %h expected 1234ffff", res); end
    n_cmp++; if (dz !== 1'b1 || wr !== 2'd3) begin n_err++; $display("FAIL dz_flag: div_zero %b wr_reg %0d expected 1/3", dz, wr); end
    n_cmp++; if (da !== 1'b0 || div_zero !== 1'b1) begin n_err++; $display("FAIL dz_hold: done %b div_zero %b expected 0/1", da, div_zero); end
    run_op(1'b0, 16'd2, 16'd3, 2'd0, lat, res, wr, dz, da);
    n_cmp++; if (dz !== 1'b0 || res !== 32'd6) begin n_err++; $display("FAIL dz_clear: div_zero %b result %h expected 0/00000006", dz, res); end
  endtask

  task automatic test_start_ignored();
    logic [15:0] x, y; int ndone, lat; logic [31:0] res;
    x = 16'($urandom); y = 16'($urandom);
    @(negedge clk); start = 1'b1; op = 1'b0; a = x; b = y; dst = 2'd3;
    @(negedge clk); start = 1'b0; op = 1'b1; a = 16'h00FF; b = 16'h0003; dst = 2'd0;
    ndone = 0; lat = -1; res = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin ndone++; if (lat < 0) begin lat = k; res = result; end end
      start = (k == 4);
    end
    start = 1'b0;
    $display("op=MUL a=%h b=%h with stray start -> result=%h dones=%0d latency=%0d", x, y, res, ndone, lat);
    n_cmp++; if (ndone !== 1) begin n_err++; $display("FAIL ignore_start_count: got %0d dones expected 1", ndone); end
    n_cmp++; if (lat !== 16 || res !== 32'(x) * 32'(y)) begin n_err++; $display("FAIL ignore_start_result: latency %0d result %h expected 16/%h", lat, res, 32'(x) * 32'(y)); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] x1, y1, x2, y2; int lat1, lat2; logic [31:0] res1, res2;
    logic [1:0] wr1, wr2;
    x1 = 16'($urandom); y1 = 16'($urandom);
    x2 = 16'($urandom); y2 = 16'($urandom_range(1, 255));
    @(negedge clk); start = 1'b1; op = 1'b0; a = x1; b = y1; dst = 2'd1;
    @(negedge clk); start = 1'b0;
    lat1 = -1; res1 = '0; wr1 = '0;
    for (int k = 1; k <= 40 && lat1 < 0; k++) begin
      @(negedge clk);
      if (done) begin
        lat1 = k; res1 = result; wr1 = wr_reg;
        start = 1'b1; op = 1'b1; a = x2; b = y2; dst = 2'd2;
      end
    end
    @(negedge clk); start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL b2b_accept: busy %b done %b expected 1/0", busy, done); end
    n_cmp++; if (result !== 32'(x1) * 32'(y1) || wr_reg !== 2'd1) begin n_err++; $display("FAIL b2b_hold: result %h wr_reg %0d expected %h/1", result, wr_reg, 32'(x1) * 32'(y1)); end
    lat2 = -1; res2 = '0; wr2 = '0;
    for (int k = 1; k <= 40 && lat2 < 0; k++) begin
      @(negedge clk);
      if (done) begin lat2 = k; res2 = result; wr2 = wr_reg; end
    end
    $display("op=MUL a=%h b=%h -> result=%h latency=%0d; op=DIV a=%h b=%h -> result=%h latency=%0d",
             x1, y1, res1, lat1, x2, y2, res2, lat2);
    n_cmp++; if (lat1 !== 16 || res1 !== 32'(x1) * 32'(y1) || wr1 !== 2'd1) begin n_err++; $display("FAIL b2b_first: latency %0d result %h wr %0d expected 16/%h/1", lat1, res1, wr1, 32'(x1) * 32'(y1)); end
    n_cmp++; if (lat2 !== 16 || res2 !== {x2 % y2, x2 / y2} || wr2 !== 2'd2) begin n_err++; $display("FAIL b2b_second: latency %0d result %h wr %0d expected 16/%h/2", lat2, res2, wr2, {x2 % y2, x2 / y2}); end
  endtask

  task automatic test_flush();
    logic [31:0] prev_res; logic [1:0] prev_wr; int ndone;
    prev_res = result; prev_wr = wr_reg;
    @(negedge clk); start = 1'b1; op = 1'b0; a = 16'h1111; b = 16'h2222; dst = 2'd3;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_pre_busy: got %b expected 1", busy); end
    flush = 1'b1; start = 1'b1; op = 1'b1; a = 16'd9; b = 16'd3; dst = 2'd0;
    @(negedge clk); flush = 1'b0; start = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL flush_idle: busy %b done %b expected 0/0", busy, done); end
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    $display("flush at cycle 4 with start -> activity cycles=%0d result=%h", ndone, result);
    n_cmp++; if (ndone !== 0) begin n_err++; $display("FAIL flush_no_done: got %0d active cycles expected 0", ndone); end
    n_cmp++; if (result !== prev_res || wr_reg !== prev_wr) begin n_err++; $display("FAIL flush_hold: result %h wr %0d expected %h/%0d", result, wr_reg, prev_res, prev_wr); end
  endtask

  task automatic test_reset_mid_op();
    int ndone; int lat; logic [31:0] res; logic [1:0] wr; logic dz, da;
    @(negedge clk); start = 1'b1; op = 1'b1; a = 16'hBEEF; b = 16'd13; dst = 2'd2;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++; if (result === 32'h0) begin n_err++; $display("FAIL rst_mid_precond: result %h expected nonzero from earlier ops", result); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({busy, done, div_zero} !== 3'b000 || result !== 32'h0 || wr_reg !== 2'd0) begin n_err++; $display("FAIL rst_mid_clear: flags %b result %h wr %0d expected 000/00000000/0", {busy, done, div_zero}, result, wr_reg); end
    @(negedge clk); reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    $display("reset at cycle 8 of DIV -> activity cycles afterwards=%0d", ndone);
    n_cmp++; if (ndone !== 0) begin n_err++; $display("FAIL rst_mid_no_done: got %0d active cycles expected 0", ndone); end
    run_op(1'b1, 16'hBEEF, 16'd13, 2'd2, lat, res, wr, dz, da);
    n_cmp++; if (res !== {16'hBEEF % 16'd13, 16'hBEEF / 16'd13} || lat !== 16) begin n_err++; $display("FAIL rst_recover: result %h latency %0d expected %h/16", res, lat, {16'hBEEF % 16'd13, 16'hBEEF / 16'd13}); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_start_ignored();
    test_back_to_back();
    test_flush();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
